uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter attached to the single-cycle RISC-V core's data-memory port, in parallel with data RAM. Core stores to the TXDATA register push bytes into a small FIFO. A framing FSM drains the FIFO onto a serial line as 8N1, LSB first. Status reads are combinational, so a load completes in the core's single cycle.

## Interface
- XLen, 32, data/address width of the core bus
- BaseAddr, 32'h1000_0000, base of the 16-byte register window; bits [3:0] must be zero
- FifoDepth, 8, FIFO entries; power of two, ≥2
- ClksPerBit, 16, clk_i cycles per serial bit; ≥2
- clk_i  in  1  system clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- dmem_addr_i  in  XLen  core data address (ALU result)
- dmem_we_i  in  1  core store strobe; one store per cycle it is high
- dmem_wdata_i  in  XLen  core store data
- dmem_rdata_o  out  XLen  register read data, combinational; 0 when hit_o=0
- hit_o  out  1  combinational; high when dmem_addr_i[XLen-1:4] == BaseAddr[XLen-1:4]; SoC uses it to select rdata and gate RAM we
- tx_o  out  1  serial output, registered, idle high
- busy_o  out  1  registered; FSM not IDLE or FIFO non-empty

## Operation
- Register map (offset = dmem_addr_i[3:0]); accesses use word offsets only:
  - 0x0 TXDATA. Write pushes dmem_wdata_i[7:0]. Read returns 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
    - bits[15:8] FIFO count, zero-extended.
    - Writing with wdata[3]=1 clears overflow. Other bits are ignored.
  - 0x8, 0xC: reads return 0; writes are ignored.
- Push condition: hit_o & dmem_we_i & offset==0x0.
  - Push while full (no simultaneous pop): data dropped, overflow set.
  - Push and pop in the same cycle while full: push accepted, count unchanged, no overflow.
- FIFO: circular buffer with wrapping read and write pointers and a count from 0 to FifoDepth; full = count==FifoDepth.
- FSM states:
  - IDLE: tx_o=1. If FIFO non-empty, pop the head into an 8-bit shift register and go to START.
  - START: tx_o=0 for ClksPerBit cycles, then DATA.
  - DATA: tx_o = shift[0]. Shift right every ClksPerBit cycles. Bit counter runs 0..7; after the 8th bit period, go to STOP.
  - STOP: tx_o=1 for ClksPerBit cycles, then IDLE.
- Baud counter: counts 0..ClksPerBit-1 and resets to 0 on every state change. Width is $clog2(ClksPerBit).
- No pop occurs outside IDLE. A byte pushed into an empty FIFO while IDLE is popped the following cycle.
- Reset (any time, including mid-frame):
  - FIFO emptied, pointers and count 0, overflow 0.
  - State IDLE, tx_o=1 immediately (asynchronous), busy_o=0.

## Timing
- Store in cycle 0 → FIFO non-empty in cycle 1 → pop at end of cycle 1 → tx_o=0 from cycle 2.
- Frame length is exactly 10·ClksPerBit cycles: start, 8 data bits, stop.
- Back-to-back bytes: one IDLE cycle between a STOP and the next START. Frame period is 10·ClksPerBit+1 cycles.
- dmem_rdata_o and hit_o are purely combinational from dmem_addr_i and current state. STATUS reflects state before the current cycle's edge.
- busy_o updates one cycle after the push or the final STOP cycle.
- Multiple consecutive store cycles push one byte each; no throttling.

## Test plan
- Reset with ClksPerBit=4, check outputs:
  - tx_o=1, busy_o=0.
  - STATUS read at 0x1000_0004 returns 0x0000_0002 (empty).
- Store 0xA5 to 0x1000_0000 in cycle 0:
  - tx_o low for cycles 2–5.
  - Data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop high for cycles 38–41.
  - busy_o drops at cycle 42.
- Nine back-to-back stores, FifoDepth=8, FSM idle at start:
  - First byte popped in cycle after first store; all 9 accepted; no overflow.
  - Eleven stores instead: STATUS bit3=1 and count=8 after the last store.
  - Write 0x8 to STATUS: overflow clears.
- Address decode:
  - Store to 0x1000_0010 and to 0x0000_0000: hit_o=0, no push, dmem_rdata_o=0.
  - Read 0x1000_0008: returns 0.
- Full FIFO with pop in the same cycle as a push: count stays 8, overflow stays 0, pushed byte later transmitted in order.
- Assert rst_ni low mid-DATA of a frame with 3 bytes queued:
  - tx_o=1 asynchronously, STATUS=0x2 after release.
  - No further frames transmitted.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core data port: TXDATA stores fill a FIFO,
// a framing FSM drains it LSB first, and STATUS is readable in the same cycle.
module uart_tx_mmio #(
    parameter int unsigned         XLen       = 32,
    parameter logic [XLen-1:0]     BaseAddr   = 32'h1000_0000,
    parameter int unsigned         FifoDepth  = 8,
    parameter int unsigned         ClksPerBit = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLen-1:0] dmem_addr_i,
    input  logic            dmem_we_i,
    input  logic [XLen-1:0] dmem_wdata_i,
    output logic [XLen-1:0] dmem_rdata_o,
    output logic            hit_o,
    output logic            tx_o,
    output logic            busy_o
);

    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(ClksPerBit);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    logic [7:0]      fifo_mem_r [FifoDepth];
    logic [PtrW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CntW-1:0] count_r, count_s;
    logic            ovf_r;
    state_e          state_r, state_s;
    logic [BaudW-1:0] baud_r, baud_s;
    logic [2:0]      bit_r, bit_s;
    logic [7:0]      shift_r, shift_s;
    logic            tx_r, tx_s, busy_r, busy_s;
    logic            hit_s, push_req_s, push_s, pop_s, full_s, empty_s;
    logic            ovf_set_s, ovf_clr_s, baud_last_s;
    logic [3:0]      offset_s;
    logic [31:0]     status_s;
    logic            unused_s;

    assign unused_s    = ^dmem_wdata_i[XLen-1:8];
    assign offset_s    = dmem_addr_i[3:0];
    assign hit_s       = (dmem_addr_i[XLen-1:4] == BaseAddr[XLen-1:4]);
    assign full_s      = (count_r == CntW'(FifoDepth));
    assign empty_s     = (count_r == {CntW{1'b0}});
    assign push_req_s  = hit_s & dmem_we_i & (offset_s == 4'h0);
    assign pop_s       = (state_r == ST_IDLE) & ~empty_s;
    // A full FIFO still takes a push when the FSM frees a slot in the same cycle
    assign push_s      = push_req_s & (~full_s | pop_s);
    assign ovf_set_s   = push_req_s & full_s & ~pop_s;
    assign ovf_clr_s   = hit_s & dmem_we_i & (offset_s == 4'h4) & dmem_wdata_i[3];
    assign baud_last_s = (baud_r == BaudW'(ClksPerBit - 1));

    assign status_s     = {16'h0000, 8'(count_r), 4'h0, ovf_r, busy_r, empty_s, full_s};
    assign hit_o        = hit_s;
    assign dmem_rdata_o = (hit_s && offset_s == 4'h4) ? XLen'(status_s) : {XLen{1'b0}};
    assign tx_o         = tx_r;
    assign busy_o       = busy_r;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CntW'(1);
            2'b01:   count_s = count_r - CntW'(1);
            default: count_s = count_r;
        endcase
    end

    // Framing FSM next state, baud/bit counters, shifter and next line level
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r + BaudW'(1);
        bit_s   = bit_r;
        shift_s = shift_r;
        case (state_r)
            ST_IDLE: begin
                baud_s = {BaudW{1'b0}};
                if (pop_s) begin
                    shift_s = fifo_mem_r[rd_ptr_r];
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    state_s = ST_DATA;
                    baud_s  = {BaudW{1'b0}};
                    bit_s   = 3'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_s = {BaudW{1'b0}};
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        shift_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    state_s = ST_IDLE;
                    baud_s  = {BaudW{1'b0}};
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = {BaudW{1'b0}};
            end
        endcase

        // Line level is registered from the next state so it lines up with it
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_s != ST_IDLE) || (count_s != {CntW{1'b0}});
    end

    // FIFO storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= dmem_wdata_i[7:0];
        end
    end

    // FIFO pointers, count and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
            count_r <= count_s;
            if (ovf_set_s)      ovf_r <= 1'b1;
            else if (ovf_clr_s) ovf_r <= 1'b0;
            else                ovf_r <= ovf_r;
        end
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            baud_r  <= {BaudW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with ClksPerBit=4: framing, FIFO full/overflow,
// address decode and asynchronous reset mid-frame.
module tb_uart_tx_mmio;

    localparam int CPB = 4;
    localparam logic [31:0] TXD = 32'h1000_0000;
    localparam logic [31:0] STA = 32'h1000_0004;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] dmem_addr_i;
    logic        dmem_we_i;
    logic [31:0] dmem_wdata_i;
    logic [31:0] dmem_rdata_o;
    logic        hit_o, tx_o, busy_o;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] bytes_q [9] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hFF, 8'h00, 8'h96, 8'h69, 8'h7E};

    uart_tx_mmio #(.ClksPerBit(CPB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dmem_addr_i(dmem_addr_i), .dmem_we_i(dmem_we_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_rdata_o(dmem_rdata_o), .hit_o(hit_o),
        .tx_o(tx_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; stores last exactly one cycle
    task automatic step();
        @(posedge clk_i);
        #1;
        dmem_we_i = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        dmem_addr_i  = addr;
        dmem_wdata_i = data;
        dmem_we_i    = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] status_exp(input int cnt, input logic ovf, input logic busy);
        return {16'h0, 8'(cnt), 4'h0, ovf, busy, (cnt == 0), (cnt == 8)};
    endfunction

    // Called in the popping IDLE cycle; checks the 10*CPB frame cycles that follow
    task automatic expect_frame(input logic [7:0] b, input int cnt_after_pop);
        logic exp_tx;
        for (int i = 0; i < 10 * CPB; i++) begin
            step();
            if (i == 0) begin
                dmem_addr_i = STA;
                #1;
                chk("frame_status", dmem_rdata_o, status_exp(cnt_after_pop, 1'b0, 1'b1));
            end
            if (i < CPB)          exp_tx = 1'b0;
            else if (i < 9 * CPB) exp_tx = b[(i - CPB) / CPB];
            else                  exp_tx = 1'b1;
            chk("frame_tx", 32'(tx_o), 32'(exp_tx));
        end
    endtask

    initial begin
        rst_ni = 1'b0; dmem_addr_i = 32'h0; dmem_we_i = 1'b0; dmem_wdata_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tx", 32'(tx_o), 32'h1);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_ni = 1'b1;
        dmem_addr_i = STA;
        #1;
        chk("rst_hit", 32'(hit_o), 32'h1);
        chk("rst_status", dmem_rdata_o, 32'h0000_0002);

        // Single byte 0xA5: start at cycle 2, stop ends cycle 41, idle at 42
        store(TXD, 32'h0000_00A5);
        chk("txdata_hit", 32'(hit_o), 32'h1);
        chk("txdata_read0", dmem_rdata_o, 32'h0);
        step();
        chk("c1_tx", 32'(tx_o), 32'h1);
        chk("c1_busy", 32'(busy_o), 32'h1);
        dmem_addr_i = STA;
        #1;
        chk("c1_status", dmem_rdata_o, 32'h0000_0104);
        expect_frame(8'hA5, 0);
        step();
        chk("c42_busy", 32'(busy_o), 32'h0);
        chk("c42_tx", 32'(tx_o), 32'h1);
        chk("c42_status", dmem_rdata_o, 32'h0000_0002);

        // Nine back-to-back stores, then two dropped ones
        for (int k = 0; k < 9; k++) begin
            store(TXD, 32'(bytes_q[k]));
            step();
        end
        dmem_addr_i = STA;
        #1;
        chk("nine_status", dmem_rdata_o, 32'h0000_0805);
        store(TXD, 32'h0000_00EE);
        step();
        store(TXD, 32'h0000_00EF);
        step();
        dmem_addr_i = STA;
        #1;
        chk("ovf_status", dmem_rdata_o, 32'h0000_080D);
        store(STA, 32'h0000_0008);
        step();
        chk("ovf_clr_status", dmem_rdata_o, 32'h0000_0805);
        repeat (30) step();
        chk("c42b_status", dmem_rdata_o, 32'h0000_0805);
        chk("c42b_tx", 32'(tx_o), 32'h1);
        // Push while full in the popping cycle: accepted, count stays 8
        store(TXD, 32'h0000_003C);
        expect_frame(bytes_q[1], 8);
        for (int k = 2; k < 9; k++) begin
            step();
            chk("gap_tx", 32'(tx_o), 32'h1);
            expect_frame(bytes_q[k], 9 - k);
        end
        step();
        chk("gap_tx", 32'(tx_o), 32'h1);
        expect_frame(8'h3C, 0);
        step();
        chk("drain_busy", 32'(busy_o), 32'h0);
        chk("drain_status", dmem_rdata_o, 32'h0000_0002);

        // Address decode
        store(32'h1000_0010, 32'h0000_005A);
        chk("miss_hi_hit", 32'(hit_o), 32'h0);
        chk("miss_hi_rdata", dmem_rdata_o, 32'h0);
        step();
        store(32'h0000_0000, 32'h0000_005A);
        chk("miss_lo_hit", 32'(hit_o), 32'h0);
        chk("miss_lo_rdata", dmem_rdata_o, 32'h0);
        step();
        dmem_addr_i = STA;
        #1;
        chk("miss_status", dmem_rdata_o, 32'h0000_0002);
        step();
        chk("miss_busy", 32'(busy_o), 32'h0);
        chk("miss_tx", 32'(tx_o), 32'h1);
        dmem_addr_i = 32'h1000_0008;
        #1;
        chk("off8_hit", 32'(hit_o), 32'h1);
        chk("off8_rdata", dmem_rdata_o, 32'h0);

        // Reset during DATA of 0x11 (bit1=0 on cycles 10..13) with 3 bytes queued
        store(TXD, 32'h0000_0011); step();
        store(TXD, 32'h0000_0022); step();
        store(TXD, 32'h0000_0033); step();
        store(TXD, 32'h0000_0044); step();
        repeat (7) step();
        chk("mid_tx", 32'(tx_o), 32'h0);
        dmem_addr_i = STA;
        #1;
        chk("mid_status", dmem_rdata_o, 32'h0000_0304);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_tx", 32'(tx_o), 32'h1);
        chk("async_busy", 32'(busy_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("post_rst_status", dmem_rdata_o, 32'h0000_0002);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("post_rst_tx", 32'(tx_o), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
